timer_device: RTL and testbench
===============================

// Module: timer_device
// PURPOSE
// Memory-mapped countdown timer on the system bridge; its irq drives one hw_int bit of the CP0 interrupt input.
// CPU programs it with sw/lw. On expiry it raises an interrupt request. CP0 masks and latches the request.
// Supports two modes: one-shot (level irq held until acknowledged) and auto-reload (one-cycle irq pulse per period).
// PARAMETERS
// none (register file fixed: CTRL @0x0, PRESET @0x4, COUNT @0x8; address decode of the base is done by the bridge)
// PORTS
// clk      in   1   system clock
// reset    in   1   synchronous, active-high reset
// addr     in   30  word address addr[31:2]; only addr[3:2] decoded
// we       in   1   write enable, sampled at posedge clk
// wdata    in   32  write data
// rdata    out  32  read data, combinational from addr[3:2]
// irq      out  1   interrupt request to CP0 hw_int; equals irq_flag & CTRL.IM
// BEHAVIOUR
// Registers:
// - CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x behave as 00), [3] IM; [31:4] read 0, writes ignored
// - PRESET: 32-bit, R/W
// - COUNT: 32-bit, read-only, writes ignored
// - addr[3:2]==3: reads 0, writes ignored
// Reset (sync): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0.
// FSM state transitions (evaluated every posedge, after the CPU write of the same cycle is applied to CTRL):
// - IDLE: EN=1 -> LOAD.
// - LOAD: COUNT<=PRESET -> CNT.
// - CNT:
//   - EN=0 -> IDLE (COUNT frozen).
//   - COUNT>1 -> COUNT<=COUNT-1.
//   - COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT.
// - INT:
//   - MODE=01: irq_flag<=0 -> LOAD (reload next cycle).
//   - else: CTRL.EN<=0 -> IDLE; irq_flag held.
// Latency: PRESET=N>=1 with EN set at cycle 0 -> irq rises at cycle N+2 (IDLE->LOAD->N CNT cycles).
// - PRESET=0 or 1: irq at cycle 3.
// Acknowledge:
// - Any write to CTRL or PRESET clears irq_flag.
// - If expiry (CNT->INT) occurs in the same cycle as an ack write, the set wins; no interrupt is lost.
// Write timing:
// - A PRESET write during CNT does not alter the running COUNT; it is used at the next LOAD.
// - A CTRL write with EN=0 during any state -> IDLE next cycle.
// - The INT one-shot clear of EN overrides a simultaneous CPU write of EN=1 (the CPU must rewrite EN).
// IM:
// - IM=0 masks irq only; irq_flag still sets.
// - Setting IM later while irq_flag=1 raises irq immediately.
// COUNT arithmetic: unsigned 32-bit. PRESET=0xFFFFFFFF counts without overflow; there is no wrap below 0.
// Reset mid-count: all state returns to reset values next cycle. irq drops the cycle after reset is sampled.
// TESTING
// 1. Reset:
//    - Stimulus: reset high 2 cycles.
//    - Required: rdata=0 at all 3 offsets; irq=0.
// 2. One-shot:
//    - Stimulus: PRESET=5, then CTRL=0x9 (EN=1, MODE=00, IM=1).
//    - Required: COUNT reads 5,4,3,2,1; irq=1 7 cycles after the CTRL write, and it stays high.
//    - Required: CTRL reads 0x8.
//    - Stimulus: write CTRL=0x8.
//    - Required: irq=0 next cycle.
// 3. Auto-reload:
//    - Stimulus: PRESET=3, CTRL=0xB.
//    - Required: irq is a one-cycle pulse every 5 cycles (LOAD, 3x CNT, INT), repeated 4 times.
// 4. Mask:
//    - Stimulus: PRESET=2, CTRL=0x1.
//    - Required: irq stays 0 after expiry.
//    - Stimulus: write CTRL=0x8.
//    - Required: that write acks the flag, so irq stays 0.
//    - Stimulus: repeat with only IM set via a write to an unmapped offset (no ack). That write is ignored, so instead expire with IM=0, then verify irq_flag through a subsequent IM=1 write.
//    - Required: the write acks the flag; irq=0.
// 5. Ack race:
//    - Stimulus: write PRESET in exactly the CNT->INT cycle.
//    - Required: irq=1 (set wins).
// 6. Disable mid-count and reset mid-count:
//    - Stimulus: at COUNT=0x10, write CTRL=0x8.
//    - Required: COUNT frozen at 0xF or 0x10; no irq.
//    - Stimulus: assert reset at COUNT=7.
//    - Required: all registers read 0.

Source files
------------

// File: rtl/timer_device.sv
// Memory-mapped countdown timer for the system bridge; drives one CP0 hw_int bit.
// Ports: clk, reset (sync, active-high), addr[31:2], we, wdata -> rdata, irq.
module timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  ctrl_q;
  logic [3:0]  ctrl_d;
  logic [3:0]  ctrl_w;
  logic [31:0] preset_q;
  logic [31:0] preset_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        flag_q;
  logic        flag_d;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        expire;
  logic        en_w;
  logic        auto_w;
  logic        unused_addr;

  assign unused_addr = ^addr[29:2];

  assign wr_ctrl   = we && (addr[1:0] == 2'd0);
  assign wr_preset = we && (addr[1:0] == 2'd1);

  // CTRL as it stands after this cycle's CPU write
  assign ctrl_w = wr_ctrl ? wdata[3:0] : ctrl_q;
  assign en_w   = ctrl_w[0];
  assign auto_w = (ctrl_w[2:1] == 2'b01);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_w;
    count_d  = count_q;
    preset_d = wr_preset ? wdata : preset_q;
    flag_d   = flag_q;
    expire   = 1'b0;
    if (wr_ctrl || wr_preset)
      flag_d = 1'b0;
    unique case (state_q)
      // start only from an enable already held in CTRL,
      // so a fresh enable costs one settle cycle
      S_IDLE: begin
        if (ctrl_q[0] && en_w)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!en_w) begin
          state_d = S_IDLE;
        end else begin
          count_d = preset_q;
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (!en_w) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          expire  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (auto_w) begin
          flag_d  = 1'b0;
          state_d = en_w ? S_LOAD : S_IDLE;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // expiry beats a same-cycle ack
    if (expire)
      flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[1:0])
      2'd0:    rdata = {28'd0, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_device.sv
// Testbench for timer_device: directed scenarios plus randomized
// runs checked against an arithmetic timing model.
module tb_timer_device;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int failures;

  timer_device dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = {28'd0, a};
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = {28'd0, a};
    #1;
    d = rdata;
  endtask

  // Expected COUNT and irq_flag k edges after the enabling CTRL write
  // (valid for k >= 2). Period is LOAD + max(N,1) CNT + INT.
  function automatic void model(input int n, input int mode, input int k,
                                output logic [31:0] cnt,
                                output logic flag);
    int m;
    int per;
    int p;
    m   = (n < 1) ? 1 : n;
    per = m + 2;
    if (mode == 1) begin
      p    = (k - 2) % per;
      flag = (p == m);
      cnt  = (n > p) ? n - p : 0;
    end else begin
      flag = (k >= m + 2);
      cnt  = (n > k - 2) ? n - (k - 2) : 0;
    end
  endfunction

  initial begin
    logic [31:0] v;
    logic [31:0] ecnt;
    logic        eflag;
    int          n;
    int          mode;
    int          im;
    int          len;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    we       = 1'b0;
    addr     = 30'd0;
    wdata    = 32'd0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd(2'd0, v); chk("rst_ctrl", v, 0);
    rd(2'd1, v); chk("rst_preset", v, 0);
    rd(2'd2, v); chk("rst_count", v, 0);
    rd(2'd3, v); chk("rst_unmapped", v, 0);
    chk("rst_irq", {31'd0, irq}, 0);

    // one-shot
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    addr = 30'd2;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k >= 2 && k <= 6)
        chk("os_count", rdata, 32'(7 - k));
      chk("os_irq", {31'd0, irq}, (k == 7) ? 1 : 0);
    end
    repeat (3) begin
      tick();
      chk("os_irq_hold", {31'd0, irq}, 1);
    end
    rd(2'd0, v); chk("os_ctrl", v, 32'h8);
    wr(2'd0, 32'h8);
    chk("os_ack", {31'd0, irq}, 0);

    // auto-reload
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    addr = 30'd2;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("ar_irq", {31'd0, irq},
          (k >= 2 && (k - 2) % 5 == 3) ? 1 : 0);
    end
    wr(2'd0, 32'h0);

    // mask
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    repeat (8) begin
      tick();
      chk("mask_irq", {31'd0, irq}, 0);
    end
    wr(2'd0, 32'h8);
    chk("mask_ack_irq", {31'd0, irq}, 0);
    wr(2'd0, 32'h1);
    repeat (8) tick();
    chk("mask2_irq", {31'd0, irq}, 0);
    wr(2'd3, 32'h8);
    rd(2'd0, v); chk("unmapped_wr", v, 0);
    chk("unmapped_irq", {31'd0, irq}, 0);
    wr(2'd0, 32'h8);
    chk("im_ack_irq", {31'd0, irq}, 0);
    rd(2'd0, v); chk("im_ctrl", v, 32'h8);

    // ack race: PRESET write on the expiry edge
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    chk("race_pre", {31'd0, irq}, 0);
    wr(2'd1, 32'd7);
    chk("race_irq", {31'd0, irq}, 1);
    tick();
    chk("race_hold", {31'd0, irq}, 1);
    rd(2'd1, v); chk("race_preset", v, 32'd7);
    wr(2'd0, 32'h8);
    chk("race_ack", {31'd0, irq}, 0);

    // disable mid-count
    wr(2'd1, 32'h20);
    wr(2'd0, 32'h9);
    addr = 30'd2;
    repeat (18) tick();
    chk("dis_pre", rdata, 32'h10);
    wr(2'd0, 32'h8);
    rd(2'd2, v); chk("dis_count", v, 32'h10);
    repeat (5) tick();
    rd(2'd2, v); chk("dis_frozen", v, 32'h10);
    chk("dis_irq", {31'd0, irq}, 0);

    // reset mid-count
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    addr = 30'd2;
    repeat (15) tick();
    chk("rmc_pre", rdata, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(2'd0, v); chk("rmc_ctrl", v, 0);
    rd(2'd1, v); chk("rmc_preset", v, 0);
    rd(2'd2, v); chk("rmc_count", v, 0);
    chk("rmc_irq", {31'd0, irq}, 0);

    // randomized runs
    for (int t = 0; t < 12; t++) begin
      n    = int'($urandom_range(0, 9));
      mode = int'($urandom_range(0, 3));
      im   = int'($urandom_range(0, 1));
      wr(2'd0, 32'h0);
      tick();
      wr(2'd1, 32'(n));
      wr(2'd0, 32'(im * 8 + mode * 2 + 1));
      addr = 30'd2;
      len  = 3 * (((n < 1) ? 1 : n) + 2) + 2;
      for (int k = 1; k <= len; k++) begin
        tick();
        if (k >= 2) begin
          model(n, mode, k, ecnt, eflag);
          chk("rnd_count", rdata, ecnt);
          chk("rnd_irq", {31'd0, irq},
              {31'd0, eflag & (im == 1)});
        end
      end
      rd(2'd0, v);
      chk("rnd_ctrl", v,
          32'(im * 8 + mode * 2 + ((mode == 1) ? 1 : 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
